cordic_vectoring_ctrl: RTL and testbench
========================================

// Module: cordic_vectoring_ctrl
// PURPOSE
//  Sequencer for the iterative CORDIC vectoring datapath (x/y/z regs, abs pre-stage, shifters, atan LUT).
//  Accepts one vector per valid/ready handshake and issues load, quadrant pre-rotation and N iteration strobes.
//  Derives each rotation direction from the datapath's live y sign; presents the result with a valid/ready handshake.
//  Sits between the upstream sample source and the datapath; it holds no data words.
// PARAMETERS
//  WORD_WIDTH  16  datapath word width; bounds ITERATIONS
//  ITERATIONS  12  micro-rotations per vector; legal range 1..WORD_WIDTH-1
//  CNT_WIDTH   4   width of iter_idx; must satisfy 2**CNT_WIDTH >= ITERATIONS
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          asynchronous active-low reset
//  in_valid    in   1          upstream vector available
//  in_ready    out  1          controller idle and accepting
//  x_neg       in   1          MSB of the incoming x; sampled only on the accept edge
//  y_sign      in   1          MSB of the datapath's current y register
//  load        out  1          datapath captures the input vector on this edge
//  pre_rotate  out  1          with load: datapath applies abs/negate to x,y and sets z=pi (x<0 case)
//  iter_en     out  1          datapath performs one micro-rotation on this edge
//  iter_idx    out  CNT_WIDTH  shift amount / atan LUT address for the current iteration
//  rot_dir     out  1          1: x+=y>>i, y-=x>>i, z+=atan(i); 0: opposite signs
//  out_valid   out  1          datapath x (magnitude*K) and z (angle) are final
//  out_ready   in   1          downstream consumes the result
//  busy        out  1          high in ITER and DONE
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state=IDLE, counter=0. All outputs are 0, including in_ready.
//    in_ready rises in the first cycle after rst_n deasserts.
//  - FSM states: IDLE, ITER, DONE.
//    IDLE: in_ready=1; load=in_valid; pre_rotate=in_valid&x_neg (combinational).
//      Accept edge = in_valid&in_ready. Next state is ITER with counter=0.
//    ITER: iter_en=1; iter_idx=counter; rot_dir=~y_sign (combinational).
//      Counter increments on each edge. The edge where counter==ITERATIONS-1 goes to DONE with counter=0.
//    DONE: out_valid=1, held until out_ready. The edge where out_valid&out_ready goes to IDLE.
//  - Latency: ITERATIONS+1 edges from accept edge to first out_valid cycle. Throughput: 1 vector per ITERATIONS+2 cycles min.
//  - Outside ITER: iter_idx=0, iter_en=0, rot_dir=0. load and pre_rotate are never asserted outside IDLE.
//  - in_valid outside IDLE is ignored (in_ready=0). No accept in the same cycle as the DONE->IDLE edge.
//  - out_ready asserted before DONE has no effect. out_valid holds indefinitely under backpressure; no state change.
//  - ITERATIONS=1: exactly one ITER cycle with iter_idx=0.
//  - Zero vector (y_sign=0 every iteration): rot_dir=1 every cycle. This is not an error.
//  - rst_n low mid-ITER or mid-DONE: immediate return to IDLE. The result is discarded and out_valid drops asynchronously.
//  - rot_dir sampling and register updates happen on the same edge. y_sign must be the registered y, never next-y.
// STRUCTURE
//  - cordic_pkg.vh holds the shared constants:
//    state encodings IDLE=2'd0, ITER=2'd1, DONE=2'd2; default WORD_WIDTH and ITERATIONS;
//    the CNT_WIDTH derivation rule; the rot_dir polarity constants.
//    The datapath and the bench include the same file.
//  - One sub-module, cordic_iter_counter: clear, enable, terminal-count flag at ITERATIONS-1, async active-low reset.
//  - FSM and output decode live in this module. All outputs are decoded from state/counter plus the listed combinational inputs.
// TESTING
//  - Reset: rst_n=0 for 3 cycles -> all outputs 0. After release -> in_ready=1 next cycle, busy=0.
//  - Single vector (ITERATIONS=12, x_neg=0, y_sign=0, out_ready=1):
//    load=1 and pre_rotate=0 on the accept edge; 12 iter_en cycles with iter_idx 0..11 and rot_dir=1;
//    out_valid=1 on cycle 13 after accept for 1 cycle; then in_ready=1.
//  - Quadrant: x_neg=1 at accept -> pre_rotate=1 with load. y_sign toggled 1,0,1... -> rot_dir 0,1,0... same cycles.
//  - Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, in_ready=0, in_valid ignored.
//    out_ready=1 -> IDLE next cycle.
//  - Abort: rst_n pulsed low at iter_idx=6 -> all outputs 0 immediately.
//    The next vector starts again at iter_idx=0 and completes in 12 iterations.
//  - ITERATIONS=1 build: one iter_en cycle (iter_idx=0), then out_valid. Back-to-back vectors spaced exactly 3 cycles.

Source files
------------

// File: rtl/cordic_vectoring_ctrl_pkg.sv
// cordic_vectoring_ctrl_pkg: shared state encodings, defaults and rot_dir polarity
package cordic_vectoring_ctrl_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int WORD_WIDTH_DEF = 16;
  localparam int ITERATIONS_DEF = 12;
  localparam logic ROT_POS = 1'b1;
  localparam logic ROT_NEG = 1'b0;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cordic_vectoring_ctrl_if.sv
// cordic_vectoring_ctrl_if: handshake and datapath strobe bundle between source, controller and datapath
interface cordic_vectoring_ctrl_if
  import cordic_vectoring_ctrl_pkg::*;
#(parameter int CNT_WIDTH = cnt_width(ITERATIONS_DEF));
  logic in_valid, in_ready, x_neg, y_sign;
  logic load, pre_rotate, iter_en, rot_dir;
  logic out_valid, out_ready, busy;
  logic [CNT_WIDTH-1:0] iter_idx;
  modport master(output in_valid, x_neg, y_sign, out_ready,
                 input in_ready, load, pre_rotate, iter_en, iter_idx, rot_dir, out_valid, busy);
  modport slave(input in_valid, x_neg, y_sign, out_ready,
                output in_ready, load, pre_rotate, iter_en, iter_idx, rot_dir, out_valid, busy);
endinterface

// File: rtl/cordic_iter_counter.sv
// cordic_iter_counter: micro-rotation index with clear, enable and wrap at the last iteration
module cordic_iter_counter #(
  parameter int ITERATIONS = 12,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 tc
);
  assign tc = cnt == CNT_WIDTH'(ITERATIONS - 1);
  // count while enabled, wrap to zero after the terminal count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || (en && tc)) cnt <= '0;
    else if (en) cnt <= cnt + CNT_WIDTH'(1);
endmodule

// File: rtl/cordic_vectoring_ctrl.sv
// cordic_vectoring_ctrl: IDLE/ITER/DONE sequencer driving load, pre-rotation and iteration strobes
module cordic_vectoring_ctrl
  import cordic_vectoring_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ITERATIONS = ITERATIONS_DEF,
  parameter int CNT_WIDTH  = cnt_width(ITERATIONS)
) (
  input logic                    clk,
  input logic                    rst_n,
  cordic_vectoring_ctrl_if.slave bus
);
  localparam int N = (ITERATIONS > WORD_WIDTH - 1) ? WORD_WIDTH - 1 : (ITERATIONS < 1) ? 1 : ITERATIONS;
  logic [1:0] state, state_nxt;
  logic armed, tc, idle, iter, done;
  logic [CNT_WIDTH-1:0] cnt;
  assign idle = state == IDLE;
  assign iter = state == ITER;
  assign done = state == DONE;
  cordic_iter_counter #(.ITERATIONS(N), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(!iter), .en(iter), .cnt(cnt), .tc(tc)
  );
  // next-state decode; in_ready already folds in the post-reset arming
  always_comb
    state_nxt = idle ? ((bus.in_valid && bus.in_ready) ? ITER : IDLE) :
                iter ? (tc ? DONE : ITER) :
                done ? (bus.out_ready ? IDLE : DONE) : IDLE;
  // state register; reset forces IDLE and drops every decoded output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else armed <= 1'b1;
  assign bus.in_ready   = idle && armed;
  assign bus.load       = bus.in_valid && bus.in_ready;
  assign bus.pre_rotate = bus.load && bus.x_neg;
  assign bus.iter_en    = iter;
  assign bus.iter_idx   = iter ? cnt : '0;
  assign bus.rot_dir    = iter && (bus.y_sign ? ROT_NEG : ROT_POS);
  assign bus.out_valid  = done;
  assign bus.busy       = iter || done;
endmodule

// File: tb/tb_cordic_vectoring_ctrl.sv
// tb_cordic_vectoring_ctrl: directed bench with an iteration scoreboard for 12- and 1-iteration builds
module tb_cordic_vectoring_ctrl;
  import cordic_vectoring_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int failed = 0;
  int total = 0;
  typedef struct packed {logic [3:0] idx; logic dir;} exp_t;
  exp_t q[$];
  cordic_vectoring_ctrl_if #(.CNT_WIDTH(4)) b();
  cordic_vectoring_ctrl_if #(.CNT_WIDTH(1)) b1();
  cordic_vectoring_ctrl #(.WORD_WIDTH(16), .ITERATIONS(12), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  cordic_vectoring_ctrl #(.WORD_WIDTH(16), .ITERATIONS(1), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [10:0] outs();
    return {b.in_ready, b.load, b.pre_rotate, b.iter_en, b.iter_idx, b.rot_dir, b.out_valid, b.busy};
  endfunction
  function automatic logic [7:0] outs1();
    return {b1.in_ready, b1.load, b1.pre_rotate, b1.iter_en, b1.iter_idx, b1.rot_dir, b1.out_valid, b1.busy};
  endfunction
  task automatic run_vec(input logic xneg, input int ymode, input int bp, input int abort_at);
    logic ys;
    exp_t e;
    b.x_neg = xneg;
    b.in_valid = 1'b1;
    #1;
    chk("accept_strobes", {b.load, b.pre_rotate, b.in_ready, b.iter_en, b.busy}, {1'b1, xneg, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    b.x_neg = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ys = (ymode == 0) ? 1'b0 : (ymode == 1) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      b.y_sign = ys;
      q.push_back('{idx: 4'(i), dir: ~ys});
      #1;
      e = q.pop_front();
      chk("iter_step", {b.iter_en, b.iter_idx, b.rot_dir}, {1'b1, e.idx, e.dir});
      chk("iter_ctrl", {b.load, b.pre_rotate, b.in_ready, b.out_valid, b.busy}, 5'b00001);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_zero", 32'(outs()), 32'd0);
        b.y_sign = 1'b0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel_ready", 32'(b.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_ready", {b.in_ready, b.busy, b.out_valid}, 3'b100);
        return;
      end
      @(posedge clk); #1;
    end
    b.y_sign = 1'b0;
    chk("done_outs", {b.out_valid, b.busy, b.iter_en, b.iter_idx, b.rot_dir, b.in_ready}, {3'b110, 4'd0, 2'b00});
    chk("sb_empty", 32'(q.size()), 32'd0);
    if (bp > 0) begin
      b.out_ready = 1'b0;
      b.in_valid = 1'b1;
      for (int j = 0; j < bp; j++) begin
        #1;
        chk("bp_hold", {b.out_valid, b.in_ready, b.load, b.busy}, 4'b1001);
        @(posedge clk); #1;
      end
      b.in_valid = 1'b0;
      b.out_ready = 1'b1;
      #1;
      chk("bp_release", 32'(b.out_valid), 32'd1);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    chk("back_idle", {b.in_ready, b.out_valid, b.busy}, 3'b100);
  endtask
  initial begin
    b.in_valid = 1'b1; b.x_neg = 1'b1; b.y_sign = 1'b0; b.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.x_neg = 1'b0; b1.y_sign = 1'b0; b1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_zero", 32'(outs()), 32'd0);
    chk("reset_zero1", 32'(outs1()), 32'd0);
    b.in_valid = 1'b0; b.x_neg = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("release_ready_low", 32'(b.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("release_ready", {b.in_ready, b.busy}, 2'b10);
    run_vec(1'b0, 0, 0, -1);
    run_vec(1'b1, 1, 0, -1);
    run_vec(1'b0, 2, 5, -1);
    run_vec(1'b0, 0, 0, 6);
    run_vec(1'b0, 0, 0, -1);
    b1.in_valid = 1'b1;
    b1.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("it1_seq", {b1.load, b1.iter_en, b1.iter_idx, b1.rot_dir, b1.out_valid},
          (k % 3 == 0) ? 5'b10000 : (k % 3 == 1) ? 5'b01010 : 5'b00001);
      @(posedge clk); #1;
    end
    b1.in_valid = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
